// File: rtl/fft_bitrev_loader_if.sv
// AXI4-Stream style channel used for both the upstream (s00) and FFT-side (m00) ports
// of the bit-reversal loader.
interface fft_bitrev_loader_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                      tvalid;
    logic                      tready;
    logic [DATA_WIDTH-1:0]     tdata;
    logic [DATA_WIDTH/8-1:0]   tstrb;
    logic                      tlast;

    modport master (
        output tvalid,
        output tdata,
        output tstrb,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tstrb,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/fft_bitrev_loader.sv
// Buffers one frame of SIZE words in natural order and replays it in bit-reversed
// index order to a radix-2 FFT, then issues a one-cycle start pulse.
module fft_bitrev_loader #(
    parameter int SIZE       = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                s00_axi_aclk,
    input  logic                s00_axi_aresetn,
    fft_bitrev_loader_if.slave  s00_axis,
    fft_bitrev_loader_if.master m00_axis,
    output logic                start,
    output logic                frame_err
);
    localparam int              AW       = $clog2(SIZE);
    localparam logic [AW-1:0]   LAST_IDX = AW'(SIZE - 1);
    localparam logic [AW-1:0]   ZERO_IDX = AW'(0);
    localparam logic [AW-1:0]   ONE_IDX  = AW'(1);
    localparam logic [DATA_WIDTH-1:0] ZERO_WORD = {DATA_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        KICK  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [DATA_WIDTH-1:0]  r_buf [SIZE];
    logic [AW-1:0]          r_wcnt;
    logic [AW-1:0]          r_rcnt;
    logic                   r_s_tready;
    logic                   r_m_tvalid;
    logic                   r_m_tlast;
    logic [DATA_WIDTH-1:0]  r_m_tdata;
    logic                   r_start;
    logic                   r_frame_err;

    logic                   w_s_hs;
    logic                   w_m_hs;
    logic                   w_wcnt_last;
    logic                   w_rcnt_last;
    logic                   w_fill_end;
    logic [AW-1:0]          w_rcnt_inc;
    logic [DATA_WIDTH-1:0]  w_first_word;
    logic                   w_unused_tstrb;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] idx);
        logic [AW-1:0] rev;
        rev = {AW{1'b0}};
        for (int b = 0; b < AW; b++) begin
            rev[b] = idx[AW-1-b];
        end
        return rev;
    endfunction

    assign w_s_hs      = r_s_tready & s00_axis.tvalid;
    assign w_m_hs      = r_m_tvalid & m00_axis.tready;
    assign w_wcnt_last = (r_wcnt == LAST_IDX);
    assign w_rcnt_last = (r_rcnt == LAST_IDX);
    assign w_fill_end  = w_s_hs & (w_wcnt_last | s00_axis.tlast);
    assign w_rcnt_inc  = r_rcnt + ONE_IDX;
    // A one-word frame writes buffer[0] on the same edge that loads the first output.
    assign w_first_word   = (r_wcnt == ZERO_IDX) ? s00_axis.tdata : r_buf[0];
    assign w_unused_tstrb = ^s00_axis.tstrb;

    assign s00_axis.tready = r_s_tready;
    assign m00_axis.tvalid = r_m_tvalid;
    assign m00_axis.tdata  = r_m_tdata;
    assign m00_axis.tlast  = r_m_tlast;
    assign m00_axis.tstrb  = {(DATA_WIDTH/8){1'b1}};
    assign start           = r_start;
    assign frame_err       = r_frame_err;

    // State register.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FILL: begin
                if (w_fill_end) begin
                    w_state_next = DRAIN;
                end else begin
                    w_state_next = FILL;
                end
            end
            DRAIN: begin
                if (w_m_hs && w_rcnt_last) begin
                    w_state_next = KICK;
                end else begin
                    w_state_next = DRAIN;
                end
            end
            KICK: begin
                w_state_next = FILL;
            end
            default: begin
                w_state_next = FILL;
            end
        endcase
    end

    // Handshake and status flags, decoded one cycle ahead from the next state.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_s_tready  <= 1'b0;
            r_m_tvalid  <= 1'b0;
            r_start     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_s_tready  <= (w_state_next == FILL);
            r_m_tvalid  <= (w_state_next == DRAIN);
            r_start     <= (w_state_next == KICK);
            r_frame_err <= w_fill_end & (s00_axis.tlast ^ w_wcnt_last);
        end
    end

    // Write/read counters and the registered output word.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_wcnt    <= ZERO_IDX;
            r_rcnt    <= ZERO_IDX;
            r_m_tdata <= ZERO_WORD;
            r_m_tlast <= 1'b0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_fill_end) begin
                        r_m_tdata <= w_first_word;
                        r_m_tlast <= 1'b0;
                    end else if (w_s_hs) begin
                        r_wcnt <= r_wcnt + ONE_IDX;
                    end else begin
                        r_wcnt <= r_wcnt;
                    end
                end
                DRAIN: begin
                    if (w_m_hs && w_rcnt_last) begin
                        r_rcnt    <= ZERO_IDX;
                        r_m_tdata <= ZERO_WORD;
                        r_m_tlast <= 1'b0;
                    end else if (w_m_hs) begin
                        r_rcnt    <= w_rcnt_inc;
                        r_m_tdata <= r_buf[bitrev(w_rcnt_inc)];
                        r_m_tlast <= (w_rcnt_inc == LAST_IDX);
                    end else begin
                        r_rcnt <= r_rcnt;
                    end
                end
                KICK: begin
                    r_wcnt <= ZERO_IDX;
                    r_rcnt <= ZERO_IDX;
                end
                default: begin
                    r_wcnt    <= ZERO_IDX;
                    r_rcnt    <= ZERO_IDX;
                    r_m_tdata <= ZERO_WORD;
                    r_m_tlast <= 1'b0;
                end
            endcase
        end
    end

    // Frame buffer: natural-order writes during FILL, cleared in KICK so short frames pad with zero.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            for (int i = 0; i < SIZE; i++) begin
                r_buf[i] <= ZERO_WORD;
            end
        end else if (r_state == KICK) begin
            for (int i = 0; i < SIZE; i++) begin
                r_buf[i] <= ZERO_WORD;
            end
        end else if ((r_state == FILL) && w_s_hs) begin
            r_buf[r_wcnt] <= s00_axis.tdata;
        end else begin
            for (int i = 0; i < SIZE; i++) begin
                r_buf[i] <= r_buf[i];
            end
        end
    end
endmodule

// File: tb/tb_fft_bitrev_loader.sv
// Randomised self-checking bench: frames go in, a queue-based reference model predicts
// the bit-reversed output order, zero padding, frame_err and start pulses.
module tb_fft_bitrev_loader;
    localparam int SIZE = 8;
    localparam int DW   = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_bitrev_loader_if #(.DATA_WIDTH(DW)) s_if ();
    fft_bitrev_loader_if #(.DATA_WIDTH(DW)) m_if ();
    fft_bitrev_loader_if #(.DATA_WIDTH(DW)) s2_if ();
    fft_bitrev_loader_if #(.DATA_WIDTH(DW)) m2_if ();
    logic start, frame_err, start2, frame_err2;

    fft_bitrev_loader #(.SIZE(SIZE), .DATA_WIDTH(DW)) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .s00_axis        (s_if),
        .m00_axis        (m_if),
        .start           (start),
        .frame_err       (frame_err)
    );

    fft_bitrev_loader #(.SIZE(2), .DATA_WIDTH(DW)) dut2 (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .s00_axis        (s2_if),
        .m00_axis        (m2_if),
        .start           (start2),
        .frame_err       (frame_err2)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] tx_words[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int bitrev_ref(input int k, input int bits);
        int r = 0;
        for (int b = 0; b < bits; b++) r = r * 2 + ((k >> b) % 2);
        return r;
    endfunction

    // Offers tx_words as one frame (tlast on index tlast_pos, -1 = none) and checks the output.
    task automatic run_frame(input int tlast_pos, input int extra, input int rmode,
                             input int abort_at, input bit gaps);
        logic [31:0] mem [SIZE];
        logic [31:0] exp_q[$];
        logic [31:0] got_q[$];
        bit          got_last[$];
        int  nwords = tx_words.size();
        int  in_idx = 0, extra_left = extra;
        int  start_cnt = 0, err_cnt = 0, n_st = 0;
        int  last_hs_cyc = -10, start_cyc = -20, frame_end_cyc = -10, err_cyc = -20;
        bit  frame_done = 1'b0, prev_stall = 1'b0, exp_err;
        logic [31:0] prev_data = 32'd0;
        logic        prev_last = 1'b0;

        for (int i = 0; i < SIZE; i++) mem[i] = (i < nwords) ? tx_words[i] : 32'd0;
        for (int k = 0; k < SIZE; k++) exp_q.push_back(mem[bitrev_ref(k, $clog2(SIZE))]);
        exp_err = (tlast_pos != SIZE - 1);

        for (int cyc = 0; cyc < 400; cyc++) begin
            check_eq("excl", {63'd0, s_if.tready & m_if.tvalid}, 64'd0);
            if (prev_stall) begin
                check_eq("hold_data", {32'd0, m_if.tdata}, {32'd0, prev_data});
                check_eq("hold_last", {63'd0, m_if.tlast}, {63'd0, prev_last});
            end
            if (start)     begin start_cnt++; start_cyc = cyc; end
            if (frame_err) begin err_cnt++;   err_cyc   = cyc; end
            if (got_q.size() == SIZE && cyc >= last_hs_cyc + 1) break;

            if (!frame_done) begin
                s_if.tvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                s_if.tdata  = tx_words[in_idx];
                s_if.tlast  = (in_idx == tlast_pos);
            end else if (extra_left > 0) begin
                check_eq("extra_ignored", {63'd0, s_if.tready}, 64'd0);
                s_if.tvalid = 1'b1;
                s_if.tdata  = $urandom;
                s_if.tlast  = 1'b0;
                extra_left--;
            end else begin
                s_if.tvalid = 1'b0;
                s_if.tlast  = 1'b0;
            end
            case (rmode)
                0:       m_if.tready = 1'b1;
                1:       m_if.tready = !((cyc % 4 == 1) || (cyc % 4 == 2));
                default: m_if.tready = ($urandom_range(0, 2) != 0);
            endcase

            if (s_if.tvalid && s_if.tready && !frame_done) begin
                if (in_idx == nwords - 1) begin
                    frame_done    = 1'b1;
                    frame_end_cyc = cyc + 1;
                end
                in_idx++;
            end
            if (m_if.tvalid && m_if.tready) begin
                got_q.push_back(m_if.tdata);
                got_last.push_back(m_if.tlast);
                last_hs_cyc = cyc + 1;
            end
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_data  = m_if.tdata;
            prev_last  = m_if.tlast;

            if (abort_at > 0 && got_q.size() == abort_at) begin
                @(posedge clk); #1;
                rst_n = 1'b0; #1;
                check_eq("rst_tvalid", {63'd0, m_if.tvalid}, 64'd0);
                check_eq("rst_tdata",  {32'd0, m_if.tdata}, 64'd0);
                check_eq("rst_tlast",  {63'd0, m_if.tlast}, 64'd0);
                check_eq("rst_tready", {63'd0, s_if.tready}, 64'd0);
                check_eq("rst_start",  {63'd0, start}, 64'd0);
                s_if.tvalid = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                repeat (20) begin
                    @(posedge clk); #1;
                    if (start) n_st++;
                end
                check_eq("rst_nostart", 64'(n_st), 64'd0);
                check_eq("rst_refill", {63'd0, s_if.tready}, 64'd1);
                for (int k = 0; k < abort_at; k++)
                    check_eq("pre_abort_data", {32'd0, got_q[k]}, {32'd0, exp_q[k]});
                return;
            end
            @(posedge clk); #1;
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;

        check_eq("out_count", 64'(got_q.size()), 64'(SIZE));
        for (int k = 0; k < SIZE && k < got_q.size(); k++) begin
            check_eq("dout", {32'd0, got_q[k]}, {32'd0, exp_q[k]});
            check_eq("tlast", {63'd0, got_last[k]}, {63'd0, (k == SIZE - 1)});
        end
        check_eq("start_count", 64'(start_cnt), 64'd1);
        check_eq("start_time", 64'(start_cyc), 64'(last_hs_cyc));
        check_eq("err_count", 64'(err_cnt), {63'd0, exp_err});
        if (exp_err) check_eq("err_time", 64'(err_cyc), 64'(frame_end_cyc));
        check_eq("refill", {63'd0, s_if.tready}, 64'd1);
    endtask

    // Two-word frame through the SIZE=2 instance: bit reversal of 1 bit is the identity.
    task automatic run_small();
        logic [31:0] w [2];
        logic [31:0] got_q[$];
        bit          got_last[$];
        int in_idx = 0, n_start = 0, n_err = 0;
        w[0] = 32'h40490FDB;
        w[1] = 32'hC0490FDB;
        m2_if.tready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (start2)     n_start++;
            if (frame_err2) n_err++;
            s2_if.tvalid = (in_idx < 2);
            s2_if.tdata  = (in_idx < 2) ? w[in_idx] : 32'd0;
            s2_if.tlast  = (in_idx == 1);
            if (s2_if.tvalid && s2_if.tready) in_idx++;
            if (m2_if.tvalid && m2_if.tready) begin
                got_q.push_back(m2_if.tdata);
                got_last.push_back(m2_if.tlast);
            end
            @(posedge clk); #1;
        end
        s2_if.tvalid = 1'b0;
        check_eq("s2_count", 64'(got_q.size()), 64'd2);
        for (int k = 0; k < 2 && k < got_q.size(); k++) begin
            check_eq("s2_dout", {32'd0, got_q[k]}, {32'd0, w[k]});
            check_eq("s2_tlast", {63'd0, got_last[k]}, {63'd0, (k == 1)});
        end
        check_eq("s2_start", 64'(n_start), 64'd1);
        check_eq("s2_err", 64'(n_err), 64'd0);
    endtask

    initial begin
        int tp;
        s_if.tvalid  = 1'b0; s_if.tdata  = 32'd0; s_if.tlast  = 1'b0; s_if.tstrb  = 4'hF;
        m_if.tready  = 1'b1;
        s2_if.tvalid = 1'b0; s2_if.tdata = 32'd0; s2_if.tlast = 1'b0; s2_if.tstrb = 4'hF;
        m2_if.tready = 1'b1;

        #12;
        check_eq("reset_tready", {63'd0, s_if.tready}, 64'd0);
        check_eq("reset_tvalid", {63'd0, m_if.tvalid}, 64'd0);
        check_eq("reset_tdata",  {32'd0, m_if.tdata}, 64'd0);
        check_eq("reset_start",  {63'd0, start}, 64'd0);
        check_eq("reset_err",    {63'd0, frame_err}, 64'd0);
        check_eq("tstrb_ones",   {60'd0, m_if.tstrb}, 64'hF);
        @(posedge clk); #1 rst_n = 1'b1;
        check_eq("post_rst_tready0", {63'd0, s_if.tready}, 64'd0);
        @(posedge clk); #1;
        check_eq("post_rst_tready1", {63'd0, s_if.tready}, 64'd1);

        tx_words.delete();
        for (int i = 0; i < SIZE; i++) tx_words.push_back(32'(i));
        run_frame(SIZE - 1, 0, 0, 0, 1'b0);
        run_frame(SIZE - 1, 0, 1, 0, 1'b0);

        tx_words.delete();
        for (int i = 1; i <= 5; i++) tx_words.push_back(32'(i));
        run_frame(4, 0, 0, 0, 1'b0);

        tx_words.delete();
        for (int i = 0; i < SIZE; i++) tx_words.push_back(32'(i));
        run_frame(-1, 2, 0, 0, 1'b0);

        tx_words.delete();
        for (int i = 0; i < SIZE; i++) tx_words.push_back($urandom | 32'h1);
        run_frame(SIZE - 1, 0, 0, 3, 1'b0);
        tx_words.delete();
        for (int i = 0; i < SIZE; i++) tx_words.push_back(32'(i));
        run_frame(SIZE - 1, 0, 0, 0, 1'b0);

        for (int f = 0; f < 12; f++) begin
            tp = $urandom_range(0, SIZE);
            tx_words.delete();
            for (int i = 0; i < ((tp == SIZE) ? SIZE : tp + 1); i++) tx_words.push_back($urandom);
            run_frame((tp == SIZE) ? -1 : tp, $urandom_range(0, 2), 2, 0, 1'b1);
        end

        run_small();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
